exec_pipe: RTL and testbench

- Parametrised execute stage between decode (ID) and the register file.
- Adds to the current single-cycle execute: configurable data/address width, a valid/stall handshake, a multi-cycle multiplier with a configurable latency, flag-based conditional branching, and a sticky halt.
- Produces one registered write-back per accepted instruction and a combinational branch request to fetch (IF).

---
 rtl/exec_pipe.sv | 165 ++++++++++++++++
 tb/tb_exec_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_pipe.sv
// Execute stage: ALU with flags, multi-cycle multiplier, conditional branch
// and sticky halt, producing one registered write-back per instruction.
module exec_pipe #(
  parameter int unsigned WORD    = 32,
  parameter int unsigned ADDR    = 16,
  parameter int unsigned W_RD    = 5,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  output logic            stall_o,
  input  logic [3:0]      op_i,
  input  logic [2:0]      cc_i,
  input  logic [WORD-1:0] src_i,
  input  logic [WORD-1:0] dest_i,
  input  logic            wb_i,
  input  logic [W_RD-1:0] wb_rd_name_i,
  output logic            branch_o,
  output logic [ADDR-1:0] baddr_o,
  output logic            wb_o,
  output logic [W_RD-1:0] wb_rd_name_o,
  output logic [WORD-1:0] wb_rd_data_o
);

  localparam int unsigned SH = $clog2(WORD);
  localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SAR,
    OP_MUL, OP_SLT, OP_JMP, OP_HALT
  } op_e;

  op_e op;
  assign op = op_e'(op_i);

  logic            wb_q, busy_q, halted_q;
  logic [W_RD-1:0] rd_q;
  logic [WORD-1:0] data_q;
  logic            z_q, n_q, c_q, v_q;
  logic [CW-1:0]   cnt_q;
  logic [WORD-1:0] ma_q, mb_q;
  logic            mwb_q;
  logic [W_RD-1:0] mrd_q;

  logic            acc;
  logic [WORD-1:0] res_d, mul_res;
  logic            c_d, v_d, wr_op, upd_zn, upd_cv;

  function automatic logic cond_met(input logic [2:0] cc, input logic z, n, c, v);
    case (cc)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return ~z;
      3'd3:    return n ^ v;
      3'd4:    return ~(n ^ v);
      3'd5:    return c;
      default: return 1'b0;
    endcase
  endfunction

  assign stall_o  = busy_q | halted_q;
  assign acc      = v_i & ~stall_o;
  assign branch_o = acc & (op == OP_JMP) & cond_met(cc_i, z_q, n_q, c_q, v_q);
  assign baddr_o  = src_i[ADDR-1:0];

  assign wb_o         = wb_q;
  assign wb_rd_name_o = rd_q;
  assign wb_rd_data_o = data_q;

  assign mul_res = ma_q * mb_q;

  always_comb begin
    res_d  = '0;
    c_d    = 1'b0;
    v_d    = 1'b0;
    wr_op  = 1'b0;
    upd_zn = 1'b0;
    upd_cv = 1'b0;
    case (op)
      OP_ADD: begin
        {c_d, res_d} = {1'b0, dest_i} + {1'b0, src_i};
        v_d = (dest_i[WORD-1] == src_i[WORD-1]) & (res_d[WORD-1] != dest_i[WORD-1]);
        {wr_op, upd_zn, upd_cv} = 3'b111;
      end
      OP_SUB: begin
        {c_d, res_d} = {1'b0, dest_i} - {1'b0, src_i};
        v_d = (dest_i[WORD-1] != src_i[WORD-1]) & (res_d[WORD-1] != dest_i[WORD-1]);
        {wr_op, upd_zn, upd_cv} = 3'b111;
      end
      OP_AND: begin res_d = dest_i & src_i; {wr_op, upd_zn, upd_cv} = 3'b111; end
      OP_OR:  begin res_d = dest_i | src_i; {wr_op, upd_zn, upd_cv} = 3'b111; end
      OP_XOR: begin res_d = dest_i ^ src_i; {wr_op, upd_zn, upd_cv} = 3'b111; end
      OP_SHL: begin res_d = dest_i << src_i[SH-1:0]; {wr_op, upd_zn, upd_cv} = 3'b111; end
      OP_SHR: begin res_d = dest_i >> src_i[SH-1:0]; {wr_op, upd_zn, upd_cv} = 3'b111; end
      OP_SAR: begin
        res_d = $unsigned($signed(dest_i) >>> src_i[SH-1:0]);
        {wr_op, upd_zn, upd_cv} = 3'b111;
      end
      OP_MUL: begin res_d = dest_i * src_i; {wr_op, upd_zn, upd_cv} = 3'b111; end
      OP_SLT: begin
        res_d = WORD'($signed(dest_i) < $signed(src_i));
        wr_op = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      {z_q, n_q, c_q, v_q} <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      mwb_q    <= 1'b0;
      mrd_q    <= '0;
    end else begin
      wb_q <= 1'b0;
      if (busy_q) begin
        // The multiply retires on the edge where the countdown reaches 1.
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          wb_q   <= mwb_q;
          rd_q   <= mrd_q;
          data_q <= mul_res;
          z_q    <= (mul_res == '0);
          n_q    <= mul_res[WORD-1];
          c_q    <= 1'b0;
          v_q    <= 1'b0;
        end
      end else if (acc) begin
        if (op == OP_MUL && MUL_LAT > 1) begin
          ma_q   <= dest_i;
          mb_q   <= src_i;
          mwb_q  <= wb_i;
          mrd_q  <= wb_rd_name_i;
          busy_q <= 1'b1;
          cnt_q  <= CW'(MUL_LAT - 1);
        end else begin
          if (wr_op) begin
            wb_q   <= wb_i;
            rd_q   <= wb_rd_name_i;
            data_q <= res_d;
          end
          if (upd_zn) begin
            z_q <= (res_d == '0);
            n_q <= res_d[WORD-1];
          end
          if (upd_cv) begin
            c_q <= c_d;
            v_q <= v_d;
          end
          if (op == OP_HALT) halted_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_pipe.sv
// Directed bench for exec_pipe: vector table for single-cycle ops and flag
// observation through JMP, plus sequences for multiply, halt and reset.
module tb_exec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i;
  logic        stall_o;
  logic [3:0]  op_i;
  logic [2:0]  cc_i;
  logic [31:0] src_i, dest_i;
  logic        wb_i;
  logic [4:0]  wb_rd_name_i;
  logic        branch_o;
  logic [15:0] baddr_o;
  logic        wb_o;
  logic [4:0]  wb_rd_name_o;
  logic [31:0] wb_rd_data_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  exec_pipe #(.WORD(32), .ADDR(16), .W_RD(5), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .op_i(op_i), .cc_i(cc_i),
    .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i), .wb_rd_name_i(wb_rd_name_i),
    .branch_o(branch_o), .baddr_o(baddr_o), .wb_o(wb_o),
    .wb_rd_name_o(wb_rd_name_o), .wb_rd_data_o(wb_rd_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  cc;
    logic [31:0] d;
    logic [31:0] s;
    logic        wb;
    logic [4:0]  rd;
    logic        ebr;
    logic        ewb;
    logic [31:0] edata;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [3:0] op, input logic [2:0] cc, input logic [31:0] d, s,
                     input logic wb, input logic [4:0] rd, input logic ebr, ewb,
                     input logic [31:0] edata);
    vec_t x;
    x.op = op; x.cc = cc; x.d = d; x.s = s; x.wb = wb; x.rd = rd;
    x.ebr = ebr; x.ewb = ewb; x.edata = edata;
    vt.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] cc,
                       input logic [31:0] d, s, input logic wb, input logic [4:0] rd);
    v_i = v; op_i = op; cc_i = cc; dest_i = d; src_i = s; wb_i = wb; wb_rd_name_i = rd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd12, 3'd0, '0, '0, 1'b0, '0);
    step; step;
    rst = 1'b0;
    chk("reset_wb", {31'b0, wb_o}, 32'd0);
    chk("reset_rd", {27'b0, wb_rd_name_o}, 32'd0);
    chk("reset_data", wb_rd_data_o, 32'd0);
    chk("reset_stall", {31'b0, stall_o}, 32'd0);

    //   op     cc    dest          src           wb    rd     br    ewb   edata
    add(4'd0,  3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 5'd3,  1'b0, 1'b1, 32'h80000000);
    add(4'd10, 3'd3, 32'h0,        32'h00001234, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd10, 3'd4, 32'h0,        32'h00001234, 1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd10, 3'd1, 32'h0,        32'h00001234, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd10, 3'd5, 32'h0,        32'h00001234, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd10, 3'd0, 32'h0,        32'h00001234, 1'b1, 5'd1,  1'b1, 1'b0, 32'h0);
    add(4'd1,  3'd0, 32'h5,        32'h5,        1'b1, 5'd4,  1'b0, 1'b1, 32'h0);
    add(4'd10, 3'd1, 32'h0,        32'h00000040, 1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd10, 3'd2, 32'h0,        32'h00000040, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd1,  3'd0, 32'h3,        32'h5,        1'b1, 5'd5,  1'b0, 1'b1, 32'hFFFFFFFE);
    add(4'd10, 3'd5, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd10, 3'd3, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd10, 3'd2, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd7,  3'd0, 32'h80000000, 32'h00000021, 1'b1, 5'd6,  1'b0, 1'b1, 32'hC0000000);
    add(4'd10, 3'd3, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd10, 3'd5, 32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd9,  3'd0, 32'hFFFFFFFF, 32'h0,        1'b1, 5'd8,  1'b0, 1'b1, 32'h1);
    add(4'd10, 3'd3, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd10, 3'd1, 32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd5,  3'd0, 32'h1,        32'h0000001F, 1'b1, 5'd10, 1'b0, 1'b1, 32'h80000000);
    add(4'd6,  3'd0, 32'h80000000, 32'h4,        1'b1, 5'd11, 1'b0, 1'b1, 32'h08000000);
    add(4'd10, 3'd3, 32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd2,  3'd0, 32'hF0F0,     32'h0FF0,     1'b1, 5'd12, 1'b0, 1'b1, 32'h00F0);
    add(4'd3,  3'd0, 32'hF0F0,     32'h0FF0,     1'b1, 5'd13, 1'b0, 1'b1, 32'hFFF0);
    add(4'd4,  3'd0, 32'hF0F0,     32'h0FF0,     1'b1, 5'd14, 1'b0, 1'b1, 32'hFF00);
    add(4'd2,  3'd0, 32'h5,        32'hA,        1'b1, 5'd15, 1'b0, 1'b1, 32'h0);
    add(4'd10, 3'd1, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd0,  3'd0, 32'hFFFFFFFF, 32'h1,        1'b1, 5'd16, 1'b0, 1'b1, 32'h0);
    add(4'd10, 3'd5, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd10, 3'd6, 32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd10, 3'd7, 32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd10, 3'd4, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd0,  3'd0, 32'h80000000, 32'h80000000, 1'b1, 5'd17, 1'b0, 1'b1, 32'h0);
    add(4'd10, 3'd4, 32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'h0);
    add(4'd10, 3'd3, 32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0);
    add(4'd0,  3'd0, 32'h1,        32'h2,        1'b0, 5'd18, 1'b0, 1'b0, 32'h0);
    add(4'd12, 3'd0, 32'h1,        32'h2,        1'b1, 5'd19, 1'b0, 1'b0, 32'h0);
    add(4'd10, 3'd1, 32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'h0);

    foreach (vt[i]) begin
      drive(1'b1, vt[i].op, vt[i].cc, vt[i].d, vt[i].s, vt[i].wb, vt[i].rd);
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, stall_o}, 32'd0);
      chk($sformatf("v%0d_branch", i), {31'b0, branch_o}, {31'b0, vt[i].ebr});
      chk($sformatf("v%0d_baddr", i), {16'b0, baddr_o}, {16'b0, vt[i].s[15:0]});
      step;
      chk($sformatf("v%0d_wb", i), {31'b0, wb_o}, {31'b0, vt[i].ewb});
      if (vt[i].ewb) begin
        chk($sformatf("v%0d_rd", i), {27'b0, wb_rd_name_o}, {27'b0, vt[i].rd});
        chk($sformatf("v%0d_data", i), wb_rd_data_o, vt[i].edata);
      end
    end

    // MUL 0x10000*0x10000 then JMP on Z presented during the stall
    drive(1'b1, 4'd8, 3'd0, 32'h00010000, 32'h00010000, 1'b1, 5'd7);
    #1 chk("mulz_acc_stall", {31'b0, stall_o}, 32'd0);
    step;
    for (int unsigned k = 0; k < 2; k++) begin
      chk($sformatf("mulz_wb_c%0d", k + 1), {31'b0, wb_o}, 32'd0);
      drive(1'b1, 4'd10, 3'd1, '0, 32'h00000080, 1'b0, '0);
      #1;
      chk($sformatf("mulz_stall_c%0d", k + 1), {31'b0, stall_o}, 32'd1);
      chk($sformatf("mulz_branch_c%0d", k + 1), {31'b0, branch_o}, 32'd0);
      step;
    end
    chk("mulz_wb", {31'b0, wb_o}, 32'd1);
    chk("mulz_rd", {27'b0, wb_rd_name_o}, 32'd7);
    chk("mulz_data", wb_rd_data_o, 32'd0);
    #1;
    chk("mulz_stall_done", {31'b0, stall_o}, 32'd0);
    chk("mulz_branch_z", {31'b0, branch_o}, 32'd1);
    step;
    chk("mulz_jmp_nowb", {31'b0, wb_o}, 32'd0);

    // MUL 3*5 followed by ADD accepted in the write-back cycle
    drive(1'b1, 4'd8, 3'd0, 32'd3, 32'd5, 1'b1, 5'd20);
    step;
    drive(1'b1, 4'd0, 3'd0, 32'd2, 32'd3, 1'b1, 5'd9);
    step; step;
    chk("mul_wb", {31'b0, wb_o}, 32'd1);
    chk("mul_rd", {27'b0, wb_rd_name_o}, 32'd20);
    chk("mul_data", wb_rd_data_o, 32'd15);
    chk("mul_add_acc_stall", {31'b0, stall_o}, 32'd0);
    step;
    chk("add_after_mul_wb", {31'b0, wb_o}, 32'd1);
    chk("add_after_mul_rd", {27'b0, wb_rd_name_o}, 32'd9);
    chk("add_after_mul_data", wb_rd_data_o, 32'd5);

    // HALT is sticky until reset
    drive(1'b1, 4'd11, 3'd0, '0, '0, 1'b1, 5'd2);
    step;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k[0]) drive(1'b1, 4'd10, 3'd0, '0, 32'h10, 1'b0, '0);
      else      drive(1'b1, 4'd0, 3'd0, 32'd1, 32'd1, 1'b1, 5'd21);
      #1;
      chk($sformatf("halt_stall_%0d", k), {31'b0, stall_o}, 32'd1);
      chk($sformatf("halt_branch_%0d", k), {31'b0, branch_o}, 32'd0);
      step;
      chk($sformatf("halt_wb_%0d", k), {31'b0, wb_o}, 32'd0);
    end
    drive(1'b0, 4'd12, 3'd0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("halt_rst_stall", {31'b0, stall_o}, 32'd0);
    chk("halt_rst_wb", {31'b0, wb_o}, 32'd0);
    chk("halt_rst_rd", {27'b0, wb_rd_name_o}, 32'd0);
    chk("halt_rst_data", wb_rd_data_o, 32'd0);
    chk("halt_rst_branch", {31'b0, branch_o}, 32'd0);

    // Reset while a multiply is in flight abandons it
    drive(1'b1, 4'd8, 3'd0, 32'd3, 32'd5, 1'b1, 5'd22);
    step;
    drive(1'b0, 4'd12, 3'd0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      chk($sformatf("mulrst_stall_%0d", k), {31'b0, stall_o}, 32'd0);
      chk($sformatf("mulrst_wb_%0d", k), {31'b0, wb_o}, 32'd0);
      step;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
